// File: rtl/stim_phase_driver.sv
// Stimulus H-bridge phase driver: synchronised phase requests, break-before-make dead time, fault latch.
// Optional charge-balance supervision is built when CHARGE_BAL_CHECK_EN is defined.
module stim_phase_driver #(
    parameter int unsigned DEADTIME = 4,
    parameter int unsigned BAL_TOL  = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       cat,
    input  logic       ano,
    input  logic       dis,
    input  logic [1:0] ch_sel_u,
    input  logic [1:0] ch_sel_d,
    input  logic [4:0] mag,
    input  logic       fault_clr,
    output logic [3:0] elec_u,
    output logic [3:0] elec_d,
    output logic       cat_on,
    output logic       ano_on,
    output logic       dis_on,
    output logic [4:0] dac_code,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_DEAD, S_CAT, S_ANO, S_DISCH, S_FAULT
    } state_t;

    localparam logic [7:0] DEAD_LOAD = 8'(DEADTIME - 1);

    state_t     state_q, state_d, tgt_q, tgt_d;
    logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [7:0] dead_q, dead_d;
    logic [1:0] chu_q, chu_d, chd_q, chd_d, code_q, code_d;
    logic [4:0] mag_q, mag_d, dac_q, dac_d;
    logic [3:0] elec_u_q, elec_u_d, elec_d_q, elec_d_d;
    logic       cat_on_q, cat_on_d, ano_on_q, ano_on_d, dis_on_q, dis_on_d;
    logic       fault_q, fault_d, busy_q, busy_d;
    logic       en_s, cat_s, ano_s, dis_s;
    logic       en_rise, en_fall, cat_rise, ano_rise, dis_rise;
    logic       tgt_req, bal_bad, active_d;

    // Synchroniser bit order: {dis, ano, cat, en}
    assign en_s     = sync2_q[0];
    assign cat_s    = sync2_q[1];
    assign ano_s    = sync2_q[2];
    assign dis_s    = sync2_q[3];
    assign en_rise  = en_s & ~prev_q[0];
    assign en_fall  = ~en_s & prev_q[0];
    assign cat_rise = cat_s & ~prev_q[1];
    assign ano_rise = ano_s & ~prev_q[2];
    assign dis_rise = dis_s & ~prev_q[3];
    // tgt_q names the pending phase in DEAD and the running phase in CAT/ANO/DISCH
    assign tgt_req  = (tgt_q == S_CAT) ? cat_s : (tgt_q == S_ANO) ? ano_s : dis_s;

`ifdef CHARGE_BAL_CHECK_EN
    logic [CNT_W-1:0] cat_cnt_q, cat_cnt_d, ano_cnt_q, ano_cnt_d, bal_diff;

    always_comb begin
        cat_cnt_d = cat_cnt_q;
        ano_cnt_d = ano_cnt_q;
        if (en_rise) begin
            cat_cnt_d = '0;
            ano_cnt_d = '0;
        end else begin
            if (cat_on_q && cat_cnt_q != '1) cat_cnt_d = cat_cnt_q + CNT_W'(1);
            if (ano_on_q && ano_cnt_q != '1) ano_cnt_d = ano_cnt_q + CNT_W'(1);
        end
        // Compare using counts that include the current drive cycle
        bal_diff = (cat_cnt_d >= ano_cnt_d) ? (cat_cnt_d - ano_cnt_d) : (ano_cnt_d - cat_cnt_d);
        bal_bad  = bal_diff > CNT_W'(BAL_TOL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cat_cnt_q <= '0;
            ano_cnt_q <= '0;
        end else begin
            cat_cnt_q <= cat_cnt_d;
            ano_cnt_q <= ano_cnt_d;
        end
    end
`else
    assign bal_bad = 1'b0;
`endif

    always_comb begin
        sync1_d = {dis, ano, cat, en};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        state_d = state_q;
        tgt_d   = tgt_q;
        dead_d  = dead_q;
        chu_d   = chu_q;
        chd_d   = chd_q;
        mag_d   = mag_q;
        code_d  = code_q;
        case (state_q)
            S_IDLE: begin
                if (en_rise) begin
                    chu_d = ch_sel_u;
                    chd_d = ch_sel_d;
                    mag_d = mag;
                    if (cat_s && ano_s) begin
                        state_d = S_FAULT;
                        code_d  = 2'b01;
                    end else if (ch_sel_u == ch_sel_d) begin
                        state_d = S_FAULT;
                        code_d  = 2'b10;
                    end else begin
                        state_d = S_ARMED;
                    end
                end
            end
            S_FAULT: begin
                if (fault_clr && !en_s) begin
                    state_d = S_IDLE;
                    code_d  = '0;
                end
            end
            default: begin
                if (cat_s && ano_s) begin
                    state_d = S_FAULT;
                    code_d  = 2'b01;
                end else if (en_fall) begin
                    if (bal_bad) begin
                        state_d = S_FAULT;
                        code_d  = 2'b11;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    case (state_q)
                        S_ARMED: begin
                            if (cat_rise)      tgt_d = S_CAT;
                            else if (ano_rise) tgt_d = S_ANO;
                            else if (dis_rise) tgt_d = S_DISCH;
                            if (cat_rise || ano_rise || dis_rise) begin
                                state_d = S_DEAD;
                                dead_d  = DEAD_LOAD;
                            end
                        end
                        S_DEAD: begin
                            if (!tgt_req) begin
                                state_d = S_ARMED;
                            end else if (dead_q == '0) begin
                                if (tgt_q == S_DISCH && bal_bad) begin
                                    state_d = S_FAULT;
                                    code_d  = 2'b11;
                                end else begin
                                    state_d = tgt_q;
                                end
                            end else begin
                                dead_d = dead_q - 8'd1;
                            end
                        end
                        default: begin
                            if (!tgt_req) state_d = S_ARMED;
                        end
                    endcase
                end
            end
        endcase
    end

    // Outputs are registered from the next state so drives never glitch
    always_comb begin
        active_d = state_d inside {S_ARMED, S_DEAD, S_CAT, S_ANO, S_DISCH};
        elec_u_d = active_d ? (4'b0001 << chu_d) : '0;
        elec_d_d = active_d ? (4'b0001 << chd_d) : '0;
        cat_on_d = (state_d == S_CAT);
        ano_on_d = (state_d == S_ANO);
        dis_on_d = (state_d == S_DISCH);
        dac_d    = (cat_on_d || ano_on_d) ? mag_d : '0;
        fault_d  = (state_d == S_FAULT);
        busy_d   = active_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tgt_q    <= S_IDLE;
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            dead_q   <= '0;
            chu_q    <= '0;
            chd_q    <= '0;
            mag_q    <= '0;
            code_q   <= '0;
            elec_u_q <= '0;
            elec_d_q <= '0;
            cat_on_q <= 1'b0;
            ano_on_q <= 1'b0;
            dis_on_q <= 1'b0;
            dac_q    <= '0;
            fault_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            dead_q   <= dead_d;
            chu_q    <= chu_d;
            chd_q    <= chd_d;
            mag_q    <= mag_d;
            code_q   <= code_d;
            elec_u_q <= elec_u_d;
            elec_d_q <= elec_d_d;
            cat_on_q <= cat_on_d;
            ano_on_q <= ano_on_d;
            dis_on_q <= dis_on_d;
            dac_q    <= dac_d;
            fault_q  <= fault_d;
            busy_q   <= busy_d;
        end
    end

    assign elec_u     = elec_u_q;
    assign elec_d     = elec_d_q;
    assign cat_on     = cat_on_q;
    assign ano_on     = ano_on_q;
    assign dis_on     = dis_on_q;
    assign dac_code   = dac_q;
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign busy       = busy_q;

endmodule

// File: doc/stim_phase_driver.md
STIM_PHASE_DRIVER -- requirements
Module: stim_phase_driver

Interface
REQ-001 Parameter DEADTIME, default 4, cycles of break-before-make between any two conducting phases (range 1..255).
REQ-002 Parameter BAL_TOL, default 8, maximum allowed |cathodic - anodic| duration difference, in cycles.
REQ-003 Parameter CNT_W, default 16, width of phase-duration counters.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high; ports are named clk and rst.
REQ-005 clk  in  1  block clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 en, cat, ano, dis  in  1 each  stimulus-sequencer phase requests; asynchronous to clk.
REQ-008 ch_sel_u, ch_sel_d  in  2 each  upper and lower electrode channel select.
REQ-009 mag  in  5  stimulus current magnitude code.
REQ-010 fault_clr  in  1  single-cycle fault clear pulse.
REQ-011 elec_u, elec_d  out  4 each  one-hot electrode switch enables.
REQ-012 cat_on, ano_on, dis_on  out  1 each  H-bridge cathodic, anodic and discharge switch drives.
REQ-013 dac_code  out  5  current DAC code.
REQ-014 fault  out  1  fault flag; fault_code  out  2  cause.
REQ-015 busy  out  1  high in any state other than IDLE and FAULT.

Function
REQ-016 en, cat, ano and dis SHALL each pass a 2-flop synchronizer (suffix _s below); all latencies count from the _s signal.
REQ-017 FSM states: IDLE, ARMED, DEAD, CAT, ANO, DISCH, FAULT.
REQ-018 IDLE -> ARMED on en_s rising; ch_sel_u, ch_sel_d and mag are latched that cycle; later changes are ignored until the next en_s rise.
REQ-019 If latched ch_sel_u == ch_sel_d, go to FAULT with code 2'b10 instead of ARMED.
REQ-020 In ARMED and the phase states: elec_u = onehot(ch_sel_u latched), elec_d = onehot(ch_sel_d latched); both are 0 in IDLE and FAULT.
REQ-021 ARMED: a rising edge of cat_s, ano_s or dis_s loads the dead-time counter and moves to DEAD, recording the target phase.
REQ-022 DEAD: cat_on, ano_on and dis_on are all 0 for exactly DEADTIME cycles, then the target state is entered and its drive asserts on the next cycle.
REQ-023 If the target request drops during DEAD, return to ARMED without asserting any drive.
REQ-024 CAT, ANO and DISCH assert only their own drive; the request falling deasserts it one cycle later and returns to ARMED.
REQ-025 At most one of cat_on, ano_on and dis_on SHALL be high in any cycle.
REQ-026 dac_code = latched mag while cat_on or ano_on is high, else 5'd0.
REQ-027 cat_s and ano_s high together in any non-IDLE state -> FAULT, code 2'b01.
REQ-028 en_s falling in any active state -> all drives 0 the next cycle, then IDLE.
REQ-029 FAULT: all outputs 0 except fault=1 and fault_code; exit to IDLE only on fault_clr while en_s=0; fault_clr is otherwise ignored.
REQ-030 Fault priority when simultaneous: 2'b01 > 2'b10 > 2'b11.

Reset
REQ-031 rst asynchronously forces state IDLE, all outputs 0, counters and synchronizers 0, including mid-phase; drives fall without dead-time.

Configuration
REQ-032 Macro CHARGE_BAL_CHECK_EN defined: saturating CNT_W-bit counters accumulate cat_on and ano_on cycles from each en_s rise.
REQ-033 With the macro, on entry to DISCH or on en_s falling, |cat_cnt - ano_cnt| > BAL_TOL -> FAULT, code 2'b11; both counters clear on en_s rise.
REQ-034 Without the macro: no counters are built, code 2'b11 is never produced, and all other behaviour is unchanged.

Verification
REQ-035 Defaults; en, ch_u=0, ch_d=1, mag=9; cat 150 cycles; gap; ano 150; dis 5 -> elec_u=0001, elec_d=0010, each drive is preceded by exactly 4 all-off cycles, dac_code=9 only during cat_on/ano_on, no fault.
REQ-036 ch_u=ch_d=2 at en rise -> fault=1, code 10, elec all 0; fault_clr while en high ignored; fault_clr after en low -> IDLE.
REQ-037 cat and ano overlap by 1 synchronized cycle -> FAULT code 01 within 1 cycle, all drives 0.
REQ-038 With CHARGE_BAL_CHECK_EN: cat 150, ano 140, then dis -> FAULT code 11 on DISCH entry; ano 145 (diff 5) -> no fault; without the macro: cat 150, ano 140 -> no fault.
REQ-039 rst pulse mid-CAT -> cat_on, elec_u and dac_code 0 immediately; cat pulse shorter than DEADTIME -> cat_on never asserts.
